bsg_manycore_eva_to_npa_pipelined: RTL



---
 rtl/bsg_manycore_pkg.sv | 72 +++++++
 rtl/bsg_manycore_eva_npa_decode.sv | 121 ++++++++++++
 rtl/hash_function.sv | 17 +
 rtl/bsg_manycore_eva_to_npa_pipelined.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_pkg.sv
// bsg_manycore_pkg
// Shared manycore definitions used by the EVA-to-NPA translators:
//   - global and tile-group EVA layouts (packed structs, MSB first)
//   - epa_word_addr_width_gp, the word-address width of a tile DMEM
//   - eva_region_e, the EVA region class computed in front of stage 1
//   - bsg_manycore_eva_cfg_s, the runtime translation configuration
//   - eva_region(), the region classifier, and clamp_log(), used for config writes
package bsg_manycore_pkg;

    localparam int max_x_cord_width_gp    = 6;
    localparam int max_y_cord_width_gp    = 6;
    localparam int epa_word_addr_width_gp = 16;
    localparam int eva_cfg_log_width_gp   = 4;

    // EVA layout 01_yyyyyy_xxxxxx_aaaa..a_bb
    typedef struct packed {
        logic [1:0]                          remote;
        logic [max_y_cord_width_gp-1:0]      y_cord;
        logic [max_x_cord_width_gp-1:0]      x_cord;
        logic [epa_word_addr_width_gp-1:0]   addr;
        logic [1:0]                          low_bits;
    } bsg_manycore_global_addr_s;

    // EVA layout 001_yyyyyy_xxxxxx_aaa..a_bb
    typedef struct packed {
        logic [2:0]                          remote;
        logic [max_y_cord_width_gp-1:0]      y_cord;
        logic [max_x_cord_width_gp-1:0]      x_cord;
        logic [epa_word_addr_width_gp-2:0]   addr;
        logic [1:0]                          low_bits;
    } bsg_manycore_tile_group_addr_s;

    typedef enum logic [2:0] {
        e_eva_dram    = 3'd0,
        e_eva_global  = 3'd1,
        e_eva_tg      = 3'd2,
        e_eva_shared  = 3'd3,
        e_eva_invalid = 3'd4
    } eva_region_e;

    typedef struct packed {
        logic [eva_cfg_log_width_gp-1:0] tg_x_log;
        logic [eva_cfg_log_width_gp-1:0] tg_y_log;
        logic [eva_cfg_log_width_gp-1:0] stripe_log;
        logic                            dram_enable;
    } bsg_manycore_eva_cfg_s;

    // Region class from the top EVA bits: 1xxxx DRAM, 01xxx global,
    // 001xx tile-group, 00001 shared, anything else (local DMEM/CSR) invalid.
    function automatic eva_region_e eva_region(input logic [31:0] eva);
        eva_region_e r;
        if (eva[31]) begin
            r = e_eva_dram;
        end else if (eva[30]) begin
            r = e_eva_global;
        end else if (eva[29]) begin
            r = e_eva_tg;
        end else if (eva[28:27] == 2'b01) begin
            r = e_eva_shared;
        end else begin
            r = e_eva_invalid;
        end
        return r;
    endfunction

    function automatic logic [eva_cfg_log_width_gp-1:0] clamp_log(
        input logic [eva_cfg_log_width_gp-1:0] value,
        input logic [eva_cfg_log_width_gp-1:0] max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/bsg_manycore_eva_npa_decode.sv
// bsg_manycore_eva_npa_decode
// Combinational region-to-NPA mapping evaluated between stage 1 and stage 2.
// Ports: i_region/i_eva/i_tgo_x/i_tgo_y (stage-1 contents), i_cfg (runtime
// config); o_x_cord/o_y_cord/o_epa/o_invalid (next stage-2 contents).
module bsg_manycore_eva_npa_decode
    import bsg_manycore_pkg::*;
#(
    parameter int data_width_p                 = 32,
    parameter int addr_width_p                 = 28,
    parameter int x_cord_width_p               = 7,
    parameter int y_cord_width_p               = 7,
    parameter int num_tiles_x_p                = 16,
    parameter int num_tiles_y_p                = 8,
    parameter int vcache_block_size_in_words_p = 8,
    parameter int vcache_size_p                = 4096,
    parameter int dmem_start_epa_p             = 'h1000
) (
    input  eva_region_e               i_region,
    input  logic [data_width_p-1:0]   i_eva,
    input  logic [x_cord_width_p-1:0] i_tgo_x,
    input  logic [y_cord_width_p-1:0] i_tgo_y,
    input  bsg_manycore_eva_cfg_s     i_cfg,
    output logic [x_cord_width_p-1:0] o_x_cord,
    output logic [y_cord_width_p-1:0] o_y_cord,
    output logic [addr_width_p-1:0]   o_epa,
    output logic                      o_invalid
);
    localparam int lg_banks_lp       = $clog2(2*num_tiles_x_p);
    localparam int lg_tiles_x_lp     = $clog2(num_tiles_x_p);
    localparam int lg_block_lp       = $clog2(vcache_block_size_in_words_p);
    localparam int lg_vcache_size_lp = $clog2(vcache_size_p);
    localparam int hash_width_lp     = data_width_p - 3 - lg_block_lp;
    localparam logic [y_cord_width_p-1:0] y_bottom_lp = y_cord_width_p'(num_tiles_y_p + 1);

    logic [lg_banks_lp-1:0]               w_bank;
    logic [hash_width_lp-lg_banks_lp-1:0] w_index;
    logic [lg_banks_lp-1:0]               w_vc_bank;
    bsg_manycore_global_addr_s            w_gaddr;
    bsg_manycore_tile_group_addr_s        w_tgaddr;
    logic [31:0]                          w_word;
    logic [5:0]                           w_sh_x;
    logic [5:0]                           w_sh_y;
    logic [5:0]                           w_sh_addr;
    logic [31:0]                          w_stripe;
    logic [31:0]                          w_sx;
    logic [31:0]                          w_sy;
    logic [31:0]                          w_saddr;
    logic [31:0]                          w_sepa;

    // Bank/index of the striped DRAM block address (EVA bit 31 is the DRAM marker).
    hash_function #(
        .banks_p (2*num_tiles_x_p),
        .width_p (hash_width_lp)
    ) u_hash (
        .i_data  (i_eva[data_width_p-2:2+lg_block_lp]),
        .o_bank  (w_bank),
        .o_index (w_index)
    );

    // Block-memory mode: each vcache owns one contiguous vcache_size_p-word chunk.
    assign w_vc_bank = i_eva[2+lg_vcache_size_lp +: lg_banks_lp];

    assign w_gaddr  = bsg_manycore_global_addr_s'(i_eva);
    assign w_tgaddr = bsg_manycore_tile_group_addr_s'(i_eva);

    // Shared address: word address split as | addr | y | x | stripe |, with
    // field widths taken from the runtime config.
    assign w_word    = 32'(i_eva[26:2]);
    assign w_sh_x    = 6'(i_cfg.stripe_log);
    assign w_sh_y    = w_sh_x + 6'(i_cfg.tg_x_log);
    assign w_sh_addr = w_sh_y + 6'(i_cfg.tg_y_log);
    assign w_stripe  = w_word & ((32'd1 << w_sh_x) - 32'd1);
    assign w_sx      = (w_word >> w_sh_x) & ((32'd1 << i_cfg.tg_x_log) - 32'd1);
    assign w_sy      = (w_word >> w_sh_y) & ((32'd1 << i_cfg.tg_y_log) - 32'd1);
    assign w_saddr   = w_word >> w_sh_addr;
    assign w_sepa    = ((w_saddr << w_sh_x) | w_stripe) + 32'(dmem_start_epa_p);

    // Region-dependent selection of destination coordinates and EPA.
    always_comb begin
        o_x_cord  = '0;
        o_y_cord  = '0;
        o_epa     = '0;
        o_invalid = 1'b0;
        case (i_region)
            e_eva_dram: begin
                if (i_cfg.dram_enable) begin
                    o_x_cord = x_cord_width_p'(w_bank[lg_tiles_x_lp-1:0]);
                    o_y_cord = w_bank[lg_banks_lp-1] ? y_bottom_lp : '0;
                    o_epa    = addr_width_p'({w_index, i_eva[2 +: lg_block_lp]});
                end else if (i_eva[data_width_p-2]) begin
                    // Host-side memory reached through the tile at (0,1).
                    o_x_cord = '0;
                    o_y_cord = y_cord_width_p'(1);
                    o_epa    = {1'b1, i_eva[2 +: addr_width_p-1]};
                end else begin
                    o_x_cord = x_cord_width_p'(w_vc_bank[lg_tiles_x_lp-1:0]);
                    o_y_cord = w_vc_bank[lg_banks_lp-1] ? y_bottom_lp : '0;
                    o_epa    = addr_width_p'(i_eva[2 +: lg_vcache_size_lp]);
                end
            end
            e_eva_global: begin
                o_x_cord = x_cord_width_p'(w_gaddr.x_cord);
                o_y_cord = y_cord_width_p'(w_gaddr.y_cord);
                o_epa    = addr_width_p'(w_gaddr.addr);
            end
            e_eva_tg: begin
                o_x_cord = x_cord_width_p'(w_tgaddr.x_cord) + i_tgo_x;
                o_y_cord = y_cord_width_p'(w_tgaddr.y_cord) + i_tgo_y;
                o_epa    = addr_width_p'(w_tgaddr.addr);
            end
            e_eva_shared: begin
                o_x_cord = x_cord_width_p'(w_sx) + i_tgo_x;
                o_y_cord = y_cord_width_p'(w_sy) + i_tgo_y;
                o_epa    = addr_width_p'(w_sepa[epa_word_addr_width_gp-1:0]);
            end
            default: begin
                o_invalid = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/hash_function.sv
// hash_function
// DRAM bank hash for a power-of-two bank count: the low bits of the block
// address select the bank and the remaining bits become the in-bank index.
// Ports: i_data (block address), o_bank (bank number), o_index (in-bank block index).
module hash_function #(
    parameter int banks_p = 32,
    parameter int width_p = 26
) (
    input  logic [width_p-1:0]                 i_data,
    output logic [$clog2(banks_p)-1:0]         o_bank,
    output logic [width_p-$clog2(banks_p)-1:0] o_index
);
    localparam int lg_banks_lp = $clog2(banks_p);

    assign o_bank  = i_data[lg_banks_lp-1:0];
    assign o_index = i_data[width_p-1:lg_banks_lp];
endmodule

// File: rtl/bsg_manycore_eva_to_npa_pipelined.sv
// bsg_manycore_eva_to_npa_pipelined
// Two-stage EVA-to-NPA translator with runtime tile-group size, stripe
// length and DRAM mode. Stage 1 holds the request and its region class,
// stage 2 holds the translated result and drives the outputs.
// Ports:
//   clk_i, reset_n_i (async, active-low)
//   cfg_*_i / cfg_ready_o : config write, accepted only when the pipe is idle
//   v_i/ready_o, eva_i, tgo_x_i, tgo_y_i, tag_i : request (valid/ready)
//   v_o/yumi_i, x_cord_o, y_cord_o, epa_o, is_invalid_addr_o, tag_o : result (valid/yumi)
//   invalid_cnt_o : saturating invalid-translation count
// Build option: BSG_MANYCORE_EVA_NPA_INVALID_CNT_EN builds the invalid counter;
// without it invalid_cnt_o is constant zero.
module bsg_manycore_eva_to_npa_pipelined
    import bsg_manycore_pkg::*;
#(
    parameter int data_width_p                 = 32,
    parameter int addr_width_p                 = 28,
    parameter int x_cord_width_p               = 7,
    parameter int y_cord_width_p               = 7,
    parameter int num_tiles_x_p                = 16,
    parameter int num_tiles_y_p                = 8,
    parameter int vcache_block_size_in_words_p = 8,
    parameter int vcache_size_p                = 4096,
    parameter int vcache_sets_p                = 64,
    parameter int max_tg_log_p                 = 3,
    parameter int max_stripe_log_p             = 4,
    parameter int dmem_start_epa_p             = 'h1000,
    parameter int tag_width_p                  = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  cfg_v_i,
    input  logic [$clog2(max_tg_log_p+1)-1:0]     cfg_tg_x_log_i,
    input  logic [$clog2(max_tg_log_p+1)-1:0]     cfg_tg_y_log_i,
    input  logic [$clog2(max_stripe_log_p+1)-1:0] cfg_stripe_log_i,
    input  logic                                  cfg_dram_enable_i,
    output logic                                  cfg_ready_o,
    input  logic                                  v_i,
    output logic                                  ready_o,
    input  logic [data_width_p-1:0]               eva_i,
    input  logic [x_cord_width_p-1:0]             tgo_x_i,
    input  logic [y_cord_width_p-1:0]             tgo_y_i,
    input  logic [tag_width_p-1:0]                tag_i,
    output logic                                  v_o,
    input  logic                                  yumi_i,
    output logic [x_cord_width_p-1:0]             x_cord_o,
    output logic [y_cord_width_p-1:0]             y_cord_o,
    output logic [addr_width_p-1:0]               epa_o,
    output logic                                  is_invalid_addr_o,
    output logic [tag_width_p-1:0]                tag_o,
    output logic [15:0]                           invalid_cnt_o
);
    localparam bsg_manycore_eva_cfg_s cfg_reset_lp = '{
        tg_x_log:    4'd2,
        tg_y_log:    4'd2,
        stripe_log:  4'd3,
        dram_enable: 1'b1
    };

    bsg_manycore_eva_cfg_s         r_cfg;
    bsg_manycore_eva_cfg_s         w_cfg_next;
    logic                          r_s1_v;
    logic [data_width_p-1:0]       r_s1_eva;
    logic [x_cord_width_p-1:0]     r_s1_tgo_x;
    logic [y_cord_width_p-1:0]     r_s1_tgo_y;
    logic [tag_width_p-1:0]        r_s1_tag;
    eva_region_e                   r_s1_region;
    logic                          r_s2_v;
    logic [x_cord_width_p-1:0]     r_s2_x;
    logic [y_cord_width_p-1:0]     r_s2_y;
    logic [addr_width_p-1:0]       r_s2_epa;
    logic                          r_s2_invalid;
    logic [tag_width_p-1:0]        r_s2_tag;
    logic                          w_s2_ready;
    logic                          w_cfg_ready;
    logic [x_cord_width_p-1:0]     w_dec_x;
    logic [y_cord_width_p-1:0]     w_dec_y;
    logic [addr_width_p-1:0]       w_dec_epa;
    logic                          w_dec_invalid;

    // Stage 2 can accept when empty or when its result leaves this cycle.
    assign w_s2_ready  = ~r_s2_v | yumi_i;
    assign ready_o     = ~r_s1_v | w_s2_ready;
    // Config only changes with nothing in flight and nothing arriving.
    assign w_cfg_ready = ~r_s1_v & ~r_s2_v & ~v_i;
    assign cfg_ready_o = w_cfg_ready;

    assign w_cfg_next.tg_x_log    = clamp_log(eva_cfg_log_width_gp'(cfg_tg_x_log_i),
                                              eva_cfg_log_width_gp'(max_tg_log_p));
    assign w_cfg_next.tg_y_log    = clamp_log(eva_cfg_log_width_gp'(cfg_tg_y_log_i),
                                              eva_cfg_log_width_gp'(max_tg_log_p));
    assign w_cfg_next.stripe_log  = clamp_log(eva_cfg_log_width_gp'(cfg_stripe_log_i),
                                              eva_cfg_log_width_gp'(max_stripe_log_p));
    assign w_cfg_next.dram_enable = cfg_dram_enable_i;

    // Runtime configuration registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cfg <= cfg_reset_lp;
        end else if (cfg_v_i & w_cfg_ready) begin
            r_cfg <= w_cfg_next;
        end else begin
            r_cfg <= r_cfg;
        end
    end

    // Stage 1: request capture and region classification.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_s1_v      <= 1'b0;
            r_s1_eva    <= '0;
            r_s1_tgo_x  <= '0;
            r_s1_tgo_y  <= '0;
            r_s1_tag    <= '0;
            r_s1_region <= e_eva_invalid;
        end else if (ready_o) begin
            r_s1_v <= v_i;
            if (v_i) begin
                r_s1_eva    <= eva_i;
                r_s1_tgo_x  <= tgo_x_i;
                r_s1_tgo_y  <= tgo_y_i;
                r_s1_tag    <= tag_i;
                r_s1_region <= eva_region(32'(eva_i));
            end
        end
    end

    bsg_manycore_eva_npa_decode #(
        .data_width_p                 (data_width_p),
        .addr_width_p                 (addr_width_p),
        .x_cord_width_p               (x_cord_width_p),
        .y_cord_width_p               (y_cord_width_p),
        .num_tiles_x_p                (num_tiles_x_p),
        .num_tiles_y_p                (num_tiles_y_p),
        .vcache_block_size_in_words_p (vcache_block_size_in_words_p),
        .vcache_size_p                (vcache_size_p),
        .dmem_start_epa_p             (dmem_start_epa_p)
    ) u_decode (
        .i_region  (r_s1_region),
        .i_eva     (r_s1_eva),
        .i_tgo_x   (r_s1_tgo_x),
        .i_tgo_y   (r_s1_tgo_y),
        .i_cfg     (r_cfg),
        .o_x_cord  (w_dec_x),
        .o_y_cord  (w_dec_y),
        .o_epa     (w_dec_epa),
        .o_invalid (w_dec_invalid)
    );

    // Stage 2: translated result, held while the consumer stalls.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_s2_v       <= 1'b0;
            r_s2_x       <= '0;
            r_s2_y       <= '0;
            r_s2_epa     <= '0;
            r_s2_invalid <= 1'b0;
            r_s2_tag     <= '0;
        end else if (w_s2_ready) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_x       <= w_dec_x;
                r_s2_y       <= w_dec_y;
                r_s2_epa     <= w_dec_epa;
                r_s2_invalid <= w_dec_invalid;
                r_s2_tag     <= r_s1_tag;
            end
        end
    end

    assign v_o               = r_s2_v;
    assign x_cord_o          = r_s2_x;
    assign y_cord_o          = r_s2_y;
    assign epa_o             = r_s2_epa;
    assign is_invalid_addr_o = r_s2_invalid;
    assign tag_o             = r_s2_tag;

`ifdef BSG_MANYCORE_EVA_NPA_INVALID_CNT_EN
    logic [15:0] r_invalid_cnt;

    // Saturating count of invalid results taken by the consumer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_invalid_cnt <= 16'd0;
        end else if (r_s2_v & yumi_i & r_s2_invalid & (r_invalid_cnt != 16'hFFFF)) begin
            r_invalid_cnt <= r_invalid_cnt + 16'd1;
        end else begin
            r_invalid_cnt <= r_invalid_cnt;
        end
    end

    assign invalid_cnt_o = r_invalid_cnt;
`else
    assign invalid_cnt_o = 16'd0;
`endif

endmodule
